// File: rtl/lineoutput_writer_pkg.sv
// Shared constants, FSM encoding and bank indexing for the
// BufferPool line controllers.
package lineoutput_writer_pkg;

  localparam int X_MAC      = 4;
  localparam int X_MESH     = 16;
  localparam int ADDR_LEN   = 13;
  localparam int DATA_LEN   = 32;
  localparam int LINE_W     = 16;
  localparam int BUFFER_NUM = X_MAC * X_MESH;
  localparam int DATAWIDTH  = BUFFER_NUM * DATA_LEN;
  localparam int ADDRWIDTH  = BUFFER_NUM * ADDR_LEN;
  localparam int ROW_W      = $clog2(X_MESH);

  typedef enum logic [2:0] {
    IDLE,
    PADL,
    DATA,
    PADR,
    FIN
  } line_state_e;

  function automatic int bank_idx(input int i, input int j);
    return i * X_MAC + j;
  endfunction

endpackage

// File: rtl/lineoutput_writer_addr_gen.sv
// Slot, line, mesh-row and row-base counters for one write job.
// No multiply: base steps by the stride whenever the mesh row wraps.
module line_addr_gen
  import lineoutput_writer_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                init,
  input  logic                step,
  input  logic                next_line,
  input  logic [ADDR_LEN-1:0] st_addr,
  input  logic [ADDR_LEN-1:0] linelen,
  input  logic [LINE_W-1:0]   numlines,
  input  logic                ispad,
  output logic [ROW_W-1:0]    row,
  output logic [ADDR_LEN-1:0] addr,
  output logic                pad,
  output logic                last_data,
  output logic                last_line
);

  logic [ADDR_LEN-1:0] len_q;
  logic [LINE_W-1:0]   lines_q;
  logic [ADDR_LEN-1:0] base;
  logic [ADDR_LEN-1:0] slot;
  logic [LINE_W-1:0]   line;
  logic [ADDR_LEN-1:0] stride;
  logic [ADDR_LEN-1:0] pad_ext;

  assign pad_ext   = {{(ADDR_LEN-1){1'b0}}, pad};
  assign stride    = len_q + {pad_ext[ADDR_LEN-2:0], 1'b0};
  assign addr      = base + slot;
  assign last_data = (slot == len_q + pad_ext - ADDR_LEN'(1));
  assign last_line = (line == lines_q - LINE_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q   <= '0;
      lines_q <= '0;
      pad     <= 1'b0;
      base    <= '0;
      slot    <= '0;
      line    <= '0;
      row     <= '0;
    end else if (init) begin
      len_q   <= linelen;
      lines_q <= numlines;
      pad     <= ispad;
      base    <= st_addr;
      slot    <= '0;
      line    <= '0;
      row     <= '0;
    end else if (next_line) begin
      slot <= '0;
      line <= line + LINE_W'(1);
      if (row == ROW_W'(X_MESH - 1)) begin
        row  <= '0;
        base <= base + stride;
      end else begin
        row <= row + ROW_W'(1);
      end
    end else if (step) begin
      slot <= slot + ADDR_LEN'(1);
    end
  end

endmodule

// File: rtl/lineoutput_writer.sv
// BufferPool port-A write controller: streams output pixels into
// mesh rows line by line, with optional zero padding per line.
module lineoutput_writer
  import lineoutput_writer_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [ADDR_LEN-1:0]          st_addr,
  input  logic [ADDR_LEN-1:0]          linelen,
  input  logic [LINE_W-1:0]            numlines,
  input  logic                         ispad,
  input  logic [X_MAC*DATA_LEN-1:0]    in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [DATAWIDTH-1:0]         dina,
  output logic [ADDRWIDTH-1:0]         addra,
  output logic [BUFFER_NUM-1:0]        wea,
  output logic                         busy,
  output logic                         done
);

  line_state_e         state, nxt;
  logic                init, step, next_line;
  logic                wr, wr_zero;
  logic [ROW_W-1:0]    row;
  logic [ADDR_LEN-1:0] addr;
  logic                pad, last_data, last_line;

  line_addr_gen u_addr (
    .clk       (clk),
    .rst       (rst),
    .init      (init),
    .step      (step),
    .next_line (next_line),
    .st_addr   (st_addr),
    .linelen   (linelen),
    .numlines  (numlines),
    .ispad     (ispad),
    .row       (row),
    .addr      (addr),
    .pad       (pad),
    .last_data (last_data),
    .last_line (last_line)
  );

  assign in_ready = (state == DATA);
  assign busy     = (state != IDLE);
  assign done     = (state == FIN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt       = state;
    init      = 1'b0;
    step      = 1'b0;
    next_line = 1'b0;
    wr        = 1'b0;
    wr_zero   = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          init = 1'b1;
          nxt  = ispad ? PADL : DATA;
        end
      end
      PADL: begin
        wr      = 1'b1;
        wr_zero = 1'b1;
        step    = 1'b1;
        nxt     = DATA;
      end
      DATA: begin
        if (in_valid) begin
          wr = 1'b1;
          if (!last_data) begin
            step = 1'b1;
          end else if (pad) begin
            step = 1'b1;
            nxt  = PADR;
          end else begin
            next_line = 1'b1;
            nxt       = last_line ? FIN : DATA;
          end
        end
      end
      PADR: begin
        wr        = 1'b1;
        wr_zero   = 1'b1;
        next_line = 1'b1;
        nxt       = last_line ? FIN : PADL;
      end
      FIN:     nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Unselected banks are driven to zero rather than held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wea   <= '0;
      addra <= '0;
      dina  <= '0;
    end else begin
      wea   <= '0;
      addra <= '0;
      dina  <= '0;
      if (wr) begin
        for (int i = 0; i < X_MESH; i++) begin
          for (int j = 0; j < X_MAC; j++) begin
            if (row == ROW_W'(i)) begin
              wea[bank_idx(i, j)] <= 1'b1;
              addra[bank_idx(i, j)*ADDR_LEN +: ADDR_LEN] <= addr;
              dina[bank_idx(i, j)*DATA_LEN +: DATA_LEN] <=
                wr_zero ? '0 : in_data[j*DATA_LEN +: DATA_LEN];
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_lineoutput_writer.sv
// Directed bench for lineoutput_writer with a queue-based write model
// derived from the line/row/base addressing rules.
module tb_lineoutput_writer;

  localparam int XM = 4;
  localparam int XR = 16;
  localparam int AL = 13;
  localparam int DL = 32;
  localparam int NB = XM * XR;
  localparam int LIMIT = 2000;

  typedef struct {
    int           row;
    logic [AL-1:0] addr;
    logic [XM*DL-1:0] data;
  } wr_t;

  logic clk = 0;
  logic rst = 1;
  logic start = 0;
  logic [AL-1:0] st_addr = '0;
  logic [AL-1:0] linelen = '0;
  logic [15:0] numlines = '0;
  logic ispad = 0;
  logic [XM*DL-1:0] in_data = '0;
  logic in_valid = 0;
  logic in_ready;
  logic [NB*DL-1:0] dina;
  logic [NB*AL-1:0] addra;
  logic [NB-1:0] wea;
  logic busy;
  logic done;

  int nvec = 0;
  int nerr = 0;
  int tag = 0;
  wr_t q[$];

  always #5 clk = ~clk;

  lineoutput_writer dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .st_addr  (st_addr),
    .linelen  (linelen),
    .numlines (numlines),
    .ispad    (ispad),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .dina     (dina),
    .addra    (addra),
    .wea      (wea),
    .busy     (busy),
    .done     (done)
  );

  function automatic logic [XM*DL-1:0] mk(input int t, input int k);
    logic [XM*DL-1:0] r;
    for (int j = 0; j < XM; j++)
      r[j*DL +: DL] = {8'(t), 8'(j), 16'(k)};
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] req);
    nvec++;
    if (got !== req) begin
      nerr++;
      $display("FAIL %s: got %0h required %0h", nm, got, req);
    end
  endtask

  // Per-cycle comparison of port A against the expected write queue.
  wr_t e;
  logic [NB-1:0] ew;
  logic [NB*AL-1:0] ea;
  logic [NB*DL-1:0] ed;
  logic popped;
  always @(negedge clk) begin
    if (!rst) begin
      popped = 0;
      if (wea != '0) begin
        nvec++;
        if (q.size() == 0) begin
          nerr++;
          $display("FAIL unexpected_write: wea=%h required 0", wea);
        end else begin
          e = q.pop_front();
          popped = 1;
          ew = '0; ea = '0; ed = '0;
          for (int j = 0; j < XM; j++) begin
            ew[e.row*XM+j] = 1'b1;
            ea[(e.row*XM+j)*AL +: AL] = e.addr;
            ed[(e.row*XM+j)*DL +: DL] = e.data[j*DL +: DL];
          end
          if (wea !== ew || addra !== ea || dina !== ed) begin
            nerr++;
            $display("FAIL write row%0d: wea=%h req %h addr=%0d req %0d d0=%h req %h",
              e.row, wea, ew, addra[(e.row*XM)*AL +: AL], e.addr,
              dina[(e.row*XM)*DL +: DL], e.data[DL-1:0]);
          end
        end
      end
      nvec++;
      if (done !== (popped && q.size() == 0)) begin
        nerr++;
        $display("FAIL done: got %b required %b", done,
                 popped && q.size() == 0);
      end
    end
  end

  task automatic build(input logic [AL-1:0] st, input int len,
                       input int nl, input int pad);
    int s;
    logic [AL-1:0] b;
    wr_t w;
    s = len + 2 * pad;
    for (int l = 0; l < nl; l++) begin
      b = AL'(int'(st) + (l / XR) * s);
      w.row = l % XR;
      if (pad != 0) begin
        w.addr = b; w.data = '0; q.push_back(w);
      end
      for (int p = 0; p < len; p++) begin
        w.addr = b + AL'(pad + p);
        w.data = mk(tag, l * len + p);
        q.push_back(w);
      end
      if (pad != 0) begin
        w.addr = b + AL'(len + 1); w.data = '0; q.push_back(w);
      end
    end
  endtask

  task automatic run_job(input logic [AL-1:0] st, input int len,
                         input int nl, input int pad, input int gap_at,
                         input int abort_at, input bit dup);
    int total, k, g, cyc;
    bit v;
    total = len * nl;
    k = 0; g = 0; cyc = 0;
    @(negedge clk);
    st_addr = st; linelen = AL'(len); numlines = 16'(nl);
    ispad = pad[0]; start = 1;
    @(negedge clk);
    start = 0;
    if (pad != 0) chk("pad_in_ready", 64'(in_ready), 0);
    while (k < total && cyc < LIMIT) begin
      start = 0;
      if (k == abort_at) begin
        chk("busy_before_abort", 64'(busy), 1);
        in_valid = 0;
        #2 rst = 1;
        #1;
        chk("abort_wea", 64'(wea), 0);
        chk("abort_addra", 64'(addra != '0), 0);
        chk("abort_dina", 64'(dina != '0), 0);
        chk("abort_busy", 64'(busy), 0);
        chk("abort_ready", 64'(in_ready), 0);
        chk("abort_done", 64'(done), 0);
        q.delete();
        @(negedge clk);
        rst = 0;
        return;
      end
      if (k == gap_at && g < 3) begin
        v = 0; g++;
      end else begin
        v = 1;
      end
      if (dup && k == 2) begin
        start = 1; st_addr = 13'd55; linelen = 13'd7;
        numlines = 16'd3; ispad = 1;
      end
      in_valid = v;
      in_data = mk(tag, k);
      if (in_ready && v) k++;
      @(negedge clk);
      cyc++;
    end
    start = 0;
    in_valid = 0;
    cyc = 0;
    while (busy && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    @(negedge clk);
    chk("job_timeout", 64'(busy), 0);
    chk("queue_drained", 64'(q.size()), 0);
  endtask

  initial begin
    #1;
    chk("rst_wea", 64'(wea), 0);
    chk("rst_addra", 64'(addra != '0), 0);
    chk("rst_dina", 64'(dina != '0), 0);
    chk("rst_ready", 64'(in_ready), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_done", 64'(done), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 0;

    tag = 1;
    build(13'd0, 9, 2, 0);
    chk("m1_size", 64'(q.size()), 18);
    chk("m1_row", 64'(q[9].row), 1);
    chk("m1_addr", 64'(q[9].addr), 0);
    run_job(13'd0, 9, 2, 0, -1, -1, 0);

    tag = 2;
    build(13'd100, 4, 1, 1);
    chk("m2_size", 64'(q.size()), 6);
    chk("m2_first", 64'(q[0].addr), 100);
    chk("m2_last", 64'(q[5].addr), 105);
    run_job(13'd100, 4, 1, 1, -1, -1, 0);

    tag = 3;
    build(13'd40, 3, 2, 1);
    run_job(13'd40, 3, 2, 1, -1, -1, 0);

    tag = 4;
    build(13'd0, 3, 17, 0);
    chk("m3_row", 64'(q[48].row), 0);
    chk("m3_addr", 64'(q[48].addr), 3);
    run_job(13'd0, 3, 17, 0, -1, -1, 0);

    tag = 5;
    build(13'd7, 6, 2, 0);
    run_job(13'd7, 6, 2, 0, 3, -1, 0);

    tag = 6;
    build(13'd8190, 4, 1, 0);
    chk("m5_wrap", 64'(q[2].addr), 0);
    run_job(13'd8190, 4, 1, 0, -1, -1, 1);

    tag = 7;
    build(13'd20, 8, 2, 0);
    run_job(13'd20, 8, 2, 0, -1, 5, 0);

    tag = 8;
    build(13'd300, 5, 3, 1);
    run_job(13'd300, 5, 3, 1, 2, -1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
